// File: rtl/serial_addsub_dp.sv
// -----------------------------------------------------------------------------
// serial_addsub_dp
//
// Digit-serial adder/subtractor. Two WIDTH-bit operands are captured in
// parallel on an accepted start. They are then consumed DIGIT bits per clock,
// least-significant digit first, through a DIGIT-bit ripple adder whose carry
// is registered between digits. The result, the final carry and a one-cycle
// done pulse appear WIDTH/DIGIT clocks after the start was accepted.
//
// Subtraction is done as a + ~b + ~cin. With cin=0 this gives a-b, and
// cout=1 means that no borrow occurred (a >= b).
//
// Parameters
//   WIDTH : operand/result width in bits (>= 2)
//   DIGIT : bits processed per clock; must divide WIDTH exactly
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous, active-high reset
//   start    in   operation request, only sampled in IDLE
//   a, b     in   operands, captured when start is accepted
//   cin      in   carry-in (add) / borrow-in (sub), captured with operands
//   sub      in   0: a+b+cin, 1: a-b-cin, captured with operands
//   busy     out  high while digits are being processed
//   done     out  one-cycle pulse when sum/cout are valid
//   sum      out  result, held until the next operation completes
//   cout     out  final carry-out (sub mode: 1 = no borrow)
//   overflow out  signed overflow of the last result
//
// Build option
//   SERIAL_ADDSUB_OVF_EN : when defined, the operand sign bits are captured
//   and overflow reports signed overflow of the last completed operation.
//   When undefined, overflow is tied to 0 and no sign registers are built.
// -----------------------------------------------------------------------------
module serial_addsub_dp #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NDIG  = WIDTH / DIGIT;
    // A single-digit configuration still needs a 1-bit counter to be legal.
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Ripple adder over one digit. Returns {carry_out, digit_sum}.
    function automatic logic [DIGIT:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             ci
    );
        logic             c;
        logic [DIGIT-1:0] s;
        c = ci;
        s = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    // Digit datapath: the new partial sum enters the result register at the
    // MSB end, so after NDIG digits the first digit has reached bit 0.
    logic [DIGIT:0]       dig_res;
    logic [DIGIT-1:0]     dig_sum;
    logic                 dig_cout;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]     res_next;

    assign dig_res  = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);
    assign dig_sum  = dig_res[DIGIT-1:0];
    assign dig_cout = dig_res[DIGIT];
    assign res_cat  = {dig_sum, res_q};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

`ifdef SERIAL_ADDSUB_OVF_EN
    logic sign_a_q, sign_a_d;
    logic sign_b_q, sign_b_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    // Subtraction is folded into the operands once here so the
                    // digit loop is always a plain addition.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? ~cin : cin;
                    cnt_d   = '0;
                    res_d   = '0;
`ifdef SERIAL_ADDSUB_OVF_EN
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
`endif
                end
            end

            S_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_next;
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_DIG) begin
                    // Visible outputs change only here, so sum never shows a
                    // partial result.
                    state_d = S_DONE;
                    sum_d   = res_next;
                    cout_d  = dig_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d = (sign_a_q == sign_b_q) &&
                            (res_next[WIDTH-1] != sign_a_q);
`endif
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            ovf_q    <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
